// File: rtl/ifetch_pkg.sv
// Shared types and widths for the instruction fetch master.
package ifetch_pkg;
  localparam int ADDR_WIDTH = 12;
  localparam int XLEN       = 32;

  typedef enum logic [1:0] {IDLE, FETCH, DRAIN} ifetch_state_e;

  typedef struct packed {
    logic [XLEN-1:0] rdata;
    logic [XLEN-1:0] pc;
  } fetch_entry_t;
endpackage

// File: rtl/fetch_fifo.sv
// Small circular buffer with synchronous flush; head reads zero while empty.
module fetch_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 64
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         flush_i,
  input  logic                         push_i,
  input  logic [WIDTH-1:0]             push_data_i,
  input  logic                         pop_i,
  output logic [WIDTH-1:0]             head_o,
  output logic                         empty_o,
  output logic [$clog2(DEPTH+1)-1:0]   count_o
);
  localparam int CW = $clog2(DEPTH+1);
  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    rd_ptr, wr_ptr;
  logic [CW-1:0]    count_q;
  logic             do_push, do_pop;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH-1)) ? '0 : p + 1'b1;
  endfunction

  // A pop in the same cycle frees the slot a push into a full buffer needs.
  assign do_pop  = pop_i && (count_q != '0);
  assign do_push = push_i && ((count_q < CW'(DEPTH)) || do_pop);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      count_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (flush_i) begin
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data_i;
        wr_ptr      <= ptr_inc(wr_ptr);
      end
      if (do_pop) rd_ptr <= ptr_inc(rd_ptr);
      count_q <= count_q + CW'(do_push) - CW'(do_pop);
    end
  end

  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign head_o  = empty_o ? '0 : mem[rd_ptr];
endmodule

// File: rtl/instr_fetch_master.sv
// Read-only instruction fetch initiator: issues word requests, buffers
// responses with their PCs, and discards in-flight words after a redirect.
module instr_fetch_master
  import ifetch_pkg::*;
#(
  parameter int          FIFO_DEPTH = 2,
  parameter logic [31:0] BOOT_ADDR  = 32'h0000_0000
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  fetch_en_i,
  input  logic                  redirect_i,
  input  logic [XLEN-1:0]       redirect_pc_i,
  output logic                  req_o,
  output logic [ADDR_WIDTH-1:0] addr_o,
  output logic                  we_o,
  output logic [3:0]            wmask_o,
  output logic [XLEN-1:0]       wdata_o,
  input  logic [XLEN-1:0]       rdata_i,
  input  logic                  rvalid_i,
  output logic                  instr_valid_o,
  input  logic                  instr_ready_i,
  output logic [XLEN-1:0]       instr_rdata_o,
  output logic [XLEN-1:0]       instr_pc_o,
  output logic                  err_o
);
  localparam int CW = $clog2(FIFO_DEPTH+1);

  ifetch_state_e  state_q, state_d;
  logic [XLEN-1:0] pc_q;
  logic [CW-1:0]  disc_q, disc_d, out_nxt;
  logic [CW-1:0]  pcq_cnt, fifo_cnt;
  logic [CW:0]    occ;
  logic           pcq_empty, fifo_empty;
  logic           rsp_ok, pop, push_data, err_q;
  logic [XLEN-1:0] pcq_head;
  fetch_entry_t   head;

  assign we_o    = 1'b0;
  assign wmask_o = 4'h0;
  assign wdata_o = '0;
  assign addr_o  = pc_q[ADDR_WIDTH+1:2];

  // The PC queue occupancy doubles as the outstanding-request counter.
  assign rsp_ok    = rvalid_i && !pcq_empty;
  assign pop       = instr_valid_o && instr_ready_i;
  assign push_data = rsp_ok && (disc_q == '0) && !redirect_i;
  // Credit the slot being popped this cycle so a 1-cycle memory streams at full rate.
  assign occ       = {1'b0, fifo_cnt} + {1'b0, pcq_cnt} - (CW+1)'(pop);

  always_comb begin
    state_d = state_q;
    disc_d  = disc_q;
    req_o   = (state_q == FETCH) && fetch_en_i && !redirect_i &&
              (occ < (CW+1)'(FIFO_DEPTH));
    out_nxt = pcq_cnt + CW'(req_o) - CW'(rsp_ok);
    if (rsp_ok && (disc_q != '0)) disc_d = disc_q - 1'b1;
    if (redirect_i) disc_d = out_nxt;
    case (state_q)
      IDLE:  if (fetch_en_i) state_d = FETCH;
      FETCH, DRAIN: begin
        if (redirect_i)                           state_d = (out_nxt != '0) ? DRAIN : FETCH;
        else if (state_q == DRAIN && disc_d == '0) state_d = FETCH;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      pc_q    <= BOOT_ADDR;
      disc_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      disc_q  <= disc_d;
      if (redirect_i)  pc_q <= redirect_pc_i & ~32'h3;
      else if (req_o)  pc_q <= pc_q + 32'd4;
      if (rvalid_i && pcq_empty) err_q <= 1'b1;
    end
  end

  assign err_o = err_q;

  fetch_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(XLEN)) u_pcq (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .flush_i     (1'b0),
    .push_i      (req_o),
    .push_data_i (pc_q),
    .pop_i       (rsp_ok),
    .head_o      (pcq_head),
    .empty_o     (pcq_empty),
    .count_o     (pcq_cnt)
  );

  fetch_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH($bits(fetch_entry_t))) u_fifo (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .flush_i     (redirect_i),
    .push_i      (push_data),
    .push_data_i ({rdata_i, pcq_head}),
    .pop_i       (pop),
    .head_o      (head),
    .empty_o     (fifo_empty),
    .count_o     (fifo_cnt)
  );

  assign instr_valid_o = !fifo_empty;
  assign instr_rdata_o = head.rdata;
  assign instr_pc_o    = head.pc;
endmodule
